// File: rtl/fp32_mm_pkg.sv
// Shared types and defaults for the FP32 matmul sequencer slice.
package fp32_mm_pkg;

    // Default tile geometry and datapath depth.
    localparam int DEF_M_ROWS     = 4;
    localparam int DEF_N_COLS     = 4;
    localparam int DEF_PIPE_LAT   = 5;
    localparam int DEF_FIFO_DEPTH = 8;

    // Tag fields are carried at a fixed generous width and trimmed at the ports.
    localparam int TAG_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0] row;
        logic [TAG_W-1:0] col;
    } tag_t;

    // Index width for a dimension of n entries, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fp32_matmul_sequencer_if.sv
// Operand-issue, dot-result and result-stream signals of the matmul sequencer.
interface fp32_matmul_sequencer_if #(
    parameter int RW = 2,
    parameter int CW = 2
);
    logic          start;
    logic          busy;
    logic          done;
    logic          issue_valid;
    logic [RW-1:0] issue_row;
    logic [CW-1:0] issue_col;
    logic [31:0]   dot_result;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic [31:0]   out_data;

    // The sequencer side.
    modport master (
        input  start, dot_result, out_ready,
        output busy, done, issue_valid, issue_row, issue_col,
        output out_valid, out_row, out_col, out_data
    );

    // The environment side: operand buffers, dot unit and result writer.
    modport slave (
        output start, dot_result, out_ready,
        input  busy, done, issue_valid, issue_row, issue_col,
        input  out_valid, out_row, out_col, out_data
    );
endinterface

// File: rtl/fp32_mm_result_fifo.sv
// Result FIFO: registered head, no fall-through, occupancy exposed for credits.
module fp32_mm_result_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 36,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH <= 1) ? 1 : $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    // Storage, pointers and occupancy; the head slot is only rewritten after it is popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Every push had a credit reserved, so the FIFO can never be full when one arrives.
    push_not_full: assert property (@(posedge clk) disable iff (rst) push |-> (count < CNT_W'(DEPTH)));

endmodule

// File: rtl/fp32_matmul_sequencer.sv
// Issues (row, col) pairs to the non-stallable dot unit under credit control and
// collects the tagged results into the output FIFO.
module fp32_matmul_sequencer
    import fp32_mm_pkg::*;
#(
    parameter  int M_ROWS     = DEF_M_ROWS,
    parameter  int N_COLS     = DEF_N_COLS,
    parameter  int PIPE_LAT   = DEF_PIPE_LAT,
    parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int RW         = idx_width(M_ROWS),
    localparam int CW         = idx_width(N_COLS)
) (
    input logic                   clk,
    input logic                   rst,
    fp32_matmul_sequencer_if.master bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int FW    = RW + CW + 32;

    typedef struct packed {
        logic valid;
        tag_t tag;
    } stage_t;

    state_t           state;
    logic             busy_q;
    logic             done_q;
    logic [RW-1:0]    row_cnt;
    logic [CW-1:0]    col_cnt;
    stage_t           pipe [PIPE_LAT];
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   used;
    logic             has_credit;
    logic             issue_fire;
    logic             last_issue;
    logic             push;
    logic [FW-1:0]    push_data;
    logic [FW-1:0]    head;
    logic             drained;

    // A pop only frees its credit once fifo_count updates on the next cycle.
    assign used       = {1'b0, fifo_count} + {1'b0, inflight};
    assign has_credit = used < (CNT_W + 1)'(FIFO_DEPTH);
    assign issue_fire = (state == ISSUE) && has_credit;
    assign last_issue = issue_fire && (row_cnt == RW'(M_ROWS - 1)) && (col_cnt == CW'(N_COLS - 1));
    assign push       = pipe[PIPE_LAT-1].valid;
    assign push_data  = {pipe[PIPE_LAT-1].tag.row[RW-1:0], pipe[PIPE_LAT-1].tag.col[CW-1:0], bus.dot_result};
    // An empty FIFO has no valid head, so no pop can still be pending.
    assign drained    = (inflight == '0) && (fifo_count == '0);

    // Tile control: row-major issue counters and the registered busy/done flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            row_cnt <= '0;
            col_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state   <= ISSUE;
                        busy_q  <= 1'b1;
                        row_cnt <= '0;
                        col_cnt <= '0;
                    end
                end
                ISSUE: begin
                    if (issue_fire) begin
                        if (last_issue) begin
                            state <= DRAIN;
                        end else if (col_cnt == CW'(N_COLS - 1)) begin
                            col_cnt <= '0;
                            row_cnt <= row_cnt + RW'(1);
                        end else begin
                            col_cnt <= col_cnt + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag shadow of the dot pipeline; clearing it on reset discards whatever the datapath still holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0].valid   <= issue_fire;
            pipe[0].tag.row <= TAG_W'(row_cnt);
            pipe[0].tag.col <= TAG_W'(col_cnt);
            for (int i = 1; i < PIPE_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Credits held by issues still travelling through the dot pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({issue_fire, push})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    fp32_mm_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (head),
        .count     (fifo_count)
    );

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.issue_valid = issue_fire;
    assign bus.issue_row   = row_cnt;
    assign bus.issue_col   = col_cnt;
    assign bus.out_row     = head[FW-1 -: RW];
    assign bus.out_col     = head[CW+31 -: CW];
    assign bus.out_data    = head[31:0];

endmodule

// File: tb/tb_fp32_matmul_sequencer.sv
// Scoreboard bench for fp32_matmul_sequencer: default tile, 2-deep FIFO and 1x1 tile.
module tb_fp32_matmul_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    // row*4+col as an FP32 bit pattern, worked out by hand.
    localparam logic [31:0] FPTAB [16] = '{
        32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
        32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000,
        32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000,
        32'h41400000, 32'h41500000, 32'h41600000, 32'h41700000
    };

    typedef struct {
        int          row;
        int          col;
        logic [31:0] data;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    int start_a, start_b, start_c;
    int ir_a, ic_a, issues_a;
    int ir_b, ic_b, issues_b;
    int issues_c;
    bit timing_a = 1'b0;
    bit rnd_a = 1'b0;
    bit seen_c = 1'b0;
    bit hold_a = 1'b0;
    logic [1:0]  hr_a, hc_a;
    logic [31:0] hd_a;

    fp32_matmul_sequencer_if #(.RW(2), .CW(2)) a_if ();
    fp32_matmul_sequencer_if #(.RW(2), .CW(2)) b_if ();
    fp32_matmul_sequencer_if #(.RW(1), .CW(1)) c_if ();

    fp32_matmul_sequencer u_a (.clk(clk), .rst(rst), .bus(a_if));
    fp32_matmul_sequencer #(.FIFO_DEPTH(2)) u_b (.clk(clk), .rst(rst), .bus(b_if));
    fp32_matmul_sequencer #(.M_ROWS(1), .N_COLS(1)) u_c (.clk(clk), .rst(rst), .bus(c_if));

    always #5 clk = ~clk;

    // Cycle counter used to time issues, first results and done.
    always @(posedge clk) cyc <= cyc + 1;

    // Stub dot units: five-stage delay of the encoded tag, garbage when nothing is issued.
    logic [31:0] sa [5];
    logic [31:0] sb [5];
    logic [31:0] sc [5];
    always @(posedge clk) begin
        sa[0] <= a_if.issue_valid ? FPTAB[{a_if.issue_row, a_if.issue_col}] : $urandom();
        sb[0] <= b_if.issue_valid ? FPTAB[{b_if.issue_row, b_if.issue_col}] : $urandom();
        sc[0] <= c_if.issue_valid ? 32'h00000000 : $urandom();
        for (int i = 1; i < 5; i++) begin
            sa[i] <= sa[i-1];
            sb[i] <= sb[i-1];
            sc[i] <= sc[i-1];
        end
    end
    assign a_if.dot_result = sa[4];
    assign b_if.dot_result = sb[4];
    assign c_if.dot_result = sc[4];

    // Random backpressure on the default instance while enabled.
    always @(posedge clk) begin
        if (rnd_a) begin
            #1;
            a_if.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name, input string what);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: %s", name, what);
    endtask

    // Pulse start on one instance and push its expected results into that scoreboard.
    task automatic applyStimulus(input int which, input int nexp);
        exp_t e;
        @(posedge clk);
        #1;
        for (int i = 0; i < nexp; i++) begin
            e.row  = i / 4;
            e.col  = i % 4;
            e.data = FPTAB[i];
            case (which)
                0:       qa.push_back(e);
                1:       qb.push_back(e);
                default: qc.push_back(e);
            endcase
        end
        case (which)
            0: begin
                start_a = cyc; ir_a = 0; ic_a = 0; issues_a = 0;
                a_if.start = 1'b1;
            end
            1: begin
                start_b = cyc; ir_b = 0; ic_b = 0; issues_b = 0;
                b_if.start = 1'b1;
            end
            default: begin
                start_c = cyc; issues_c = 0; seen_c = 1'b0;
                c_if.start = 1'b1;
            end
        endcase
        @(posedge clk);
        #1;
        a_if.start = 1'b0;
        b_if.start = 1'b0;
        c_if.start = 1'b0;
    endtask

    // Wait (bounded) for done, check its cycle and that it lasts exactly one cycle.
    task automatic waitDone(input int which, input int budget, input int exp_lat, input string name);
        bit got = 1'b0;
        int n = 0;
        int st;
        logic d, b;
        while (!got && n < budget) begin
            @(negedge clk);
            n++;
            case (which)
                0:       got = a_if.done;
                1:       got = b_if.done;
                default: got = c_if.done;
            endcase
        end
        st = (which == 0) ? start_a : (which == 1) ? start_b : start_c;
        checkOutput({name, "_done_seen"}, 64'(got), 64'd1);
        if (got && exp_lat >= 0) begin
            checkOutput({name, "_done_cycle"}, 64'(cyc - st), 64'(exp_lat));
        end
        @(negedge clk);
        case (which)
            0:       begin d = a_if.done; b = a_if.busy; end
            1:       begin d = b_if.done; b = b_if.busy; end
            default: begin d = c_if.done; b = c_if.busy; end
        endcase
        checkOutput({name, "_after_done"}, {62'd0, d, b}, 64'd0);
    endtask

    // Monitor A: result scoreboard, head stability under backpressure, issue order and timing.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_a = 1'b0;
        end else begin
            if (hold_a) begin
                checkOutput("A_hold", {27'd0, a_if.out_valid, a_if.out_row, a_if.out_col, a_if.out_data},
                            {27'd0, 1'b1, hr_a, hc_a, hd_a});
            end
            if (a_if.out_valid && a_if.out_ready) begin
                if (qa.size() == 0) begin
                    failNow("A_result", $sformatf("unexpected result row=%0d col=%0d", a_if.out_row, a_if.out_col));
                end else begin
                    e = qa.pop_front();
                    checkOutput("A_result", {16'(a_if.out_row), 16'(a_if.out_col), a_if.out_data},
                                {e.row[15:0], e.col[15:0], e.data});
                end
            end
            hold_a = a_if.out_valid && !a_if.out_ready;
            hr_a   = a_if.out_row;
            hc_a   = a_if.out_col;
            hd_a   = a_if.out_data;
            if (a_if.issue_valid) begin
                checkOutput("A_issue_order", {32'(a_if.issue_row), 32'(a_if.issue_col)}, {ir_a, ic_a});
                if (timing_a) begin
                    checkOutput("A_issue_cycle", 64'(cyc - start_a), 64'(issues_a + 1));
                end
                issues_a++;
                ic_a++;
                if (ic_a == 4) begin
                    ic_a = 0;
                    ir_a++;
                end
            end
        end
    end

    // Monitor B: result scoreboard and issue order.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (b_if.out_valid && b_if.out_ready) begin
                if (qb.size() == 0) begin
                    failNow("B_result", $sformatf("unexpected result row=%0d col=%0d", b_if.out_row, b_if.out_col));
                end else begin
                    e = qb.pop_front();
                    checkOutput("B_result", {16'(b_if.out_row), 16'(b_if.out_col), b_if.out_data},
                                {e.row[15:0], e.col[15:0], e.data});
                end
            end
            if (b_if.issue_valid) begin
                checkOutput("B_issue_order", {32'(b_if.issue_row), 32'(b_if.issue_col)}, {ir_b, ic_b});
                issues_b++;
                ic_b++;
                if (ic_b == 4) begin
                    ic_b = 0;
                    ir_b++;
                end
            end
        end
    end

    // Monitor C: single-result scoreboard and the cycle of the first valid result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (c_if.out_valid && !seen_c) begin
                seen_c = 1'b1;
                checkOutput("C_valid_cycle", 64'(cyc - start_c), 64'd7);
            end
            if (c_if.out_valid && c_if.out_ready) begin
                if (qc.size() == 0) begin
                    failNow("C_result", "unexpected result");
                end else begin
                    e = qc.pop_front();
                    checkOutput("C_result", {16'(c_if.out_row), 16'(c_if.out_col), c_if.out_data},
                                {e.row[15:0], e.col[15:0], e.data});
                end
            end
            if (c_if.issue_valid) begin
                issues_c++;
            end
        end
    end

    // Global time limit.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence.
    initial begin
        rst = 1'b1;
        a_if.start = 1'b0; b_if.start = 1'b0; c_if.start = 1'b0;
        a_if.out_ready = 1'b1; b_if.out_ready = 1'b1; c_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_A", 64'({a_if.busy, a_if.done, a_if.issue_valid, a_if.out_valid,
                                    a_if.issue_row, a_if.issue_col, a_if.out_row, a_if.out_col, a_if.out_data}), 64'd0);
        checkOutput("reset_B", {60'd0, b_if.busy, b_if.done, b_if.issue_valid, b_if.out_valid}, 64'd0);
        checkOutput("reset_C", {60'd0, c_if.busy, c_if.done, c_if.issue_valid, c_if.out_valid}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Full-rate default tile.
        timing_a = 1'b1;
        applyStimulus(0, 16);
        waitDone(0, 100, 24, "A_tile");
        timing_a = 1'b0;
        checkOutput("A_tile_drained", 64'(qa.size()), 64'd0);
        checkOutput("A_tile_issues", 64'(issues_a), 64'd16);

        // Random backpressure.
        rnd_a = 1'b1;
        applyStimulus(0, 16);
        waitDone(0, 1000, -1, "A_random");
        rnd_a = 1'b0;
        @(posedge clk);
        #1 a_if.out_ready = 1'b1;
        checkOutput("A_random_drained", 64'(qa.size()), 64'd0);
        checkOutput("A_random_issues", 64'(issues_a), 64'd16);

        // Reset during cycle 8 of a tile, then a fresh tile.
        applyStimulus(0, 16);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        qa.delete();
        repeat (20) begin
            @(negedge clk);
            checkOutput("A_after_rst", {62'd0, a_if.out_valid, a_if.busy}, 64'd0);
        end
        timing_a = 1'b1;
        applyStimulus(0, 16);
        waitDone(0, 100, 24, "A_fresh");
        timing_a = 1'b0;
        checkOutput("A_fresh_drained", 64'(qa.size()), 64'd0);

        // Two-entry FIFO held off for 30 cycles.
        b_if.out_ready = 1'b0;
        applyStimulus(1, 16);
        repeat (29) @(posedge clk);
        #1;
        checkOutput("B_stall_issues", 64'(issues_b), 64'd2);
        b_if.out_ready = 1'b1;
        waitDone(1, 500, -1, "B_tile");
        checkOutput("B_drained", 64'(qb.size()), 64'd0);
        checkOutput("B_issues", 64'(issues_b), 64'd16);

        // 1x1 tile with an ignored second start while busy.
        applyStimulus(2, 1);
        @(posedge clk);
        #1 c_if.start = 1'b1;
        @(posedge clk);
        #1 c_if.start = 1'b0;
        waitDone(2, 50, 9, "C_tile");
        repeat (10) @(negedge clk);
        checkOutput("C_issues", 64'(issues_c), 64'd1);
        checkOutput("C_idle", {63'd0, c_if.busy}, 64'd0);
        checkOutput("C_drained", 64'(qc.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
